// File: rtl/decode_queue.sv
// RV32I decode stage with a DEPTH-entry decoded-instruction queue.
// Instructions are decoded combinationally at the fetch side. The decoded
// record is stored at the push edge and presented to dispatch from the head.

package decode_queue_pkg;
  localparam int CLASS_OP_W = 7;
  localparam int NEWOP_W    = 6;
  localparam int REG_SEL_W  = 5;

  // OP_NOP is encoding 0, so an all-zero record reads as a NOP.
  typedef enum logic [NEWOP_W-1:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND
  } newop_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CLASS_OP_W-1:0] classop_out,
  output logic [NEWOP_W-1:0]    newop_out,
  output logic [XLEN-1:0]       pc_out,
  output logic [REG_SEL_W-1:0]  rs1_out,
  output logic [REG_SEL_W-1:0]  rs2_out,
  output logic [REG_SEL_W-1:0]  rd_out,
  output logic [XLEN-1:0]       imm_out,
  output logic                  wr_rd_out,
  output logic                  lock_prefix,
  output logic                  illegal_out,
  output logic [PTR_W:0]        count
);

  typedef struct packed {
    logic [CLASS_OP_W-1:0] classop;
    newop_e                newop;
    logic [XLEN-1:0]       pc;
    logic [REG_SEL_W-1:0]  rs1;
    logic [REG_SEL_W-1:0]  rs2;
    logic [REG_SEL_W-1:0]  rd;
    logic [XLEN-1:0]       imm;
    logic                  wr_rd;
    logic                  lock;
    logic                  illegal;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            f7_ok;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  entry_t          dec;

  entry_t          mem_q [DEPTH];
  entry_t          head_entry;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign f7_ok  = (funct7 == 7'h00) || (funct7 == 7'h20);

  // Format immediates; $signed then size-cast sign-extends to XLEN.
  assign imm_i  = XLEN'($signed(in_inst[31:20]));
  assign imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign imm_sh = XLEN'(in_inst[24:20]);

  // Combinational decode of the incoming instruction into a queue record.
  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    dec         = '0;
    dec.classop = opcode;
    dec.pc      = in_pc;
    dec.rs1     = in_inst[19:15];
    dec.rs2     = in_inst[24:20];
    dec.rd      = in_inst[11:7];
    dec.lock    = ~(in_inst[4] | in_inst[6]);
    dec.newop   = OP_NOP;
    dec.illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec.newop = (opcode == OPC_LUI) ? OP_LUI : OP_AUIPC;
        dec.imm   = imm_u;
        dec.rs1   = '0;
        dec.rs2   = '0;
      end
      OPC_JAL: begin
        dec.newop = OP_JAL;
        dec.imm   = imm_j;
        dec.rs1   = '0;
        dec.rs2   = '0;
      end
      OPC_JALR: begin
        dec.newop = OP_JALR;
        dec.imm   = imm_i;
        dec.rs2   = '0;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b;
        dec.rd  = '0;
        case (funct3)
          3'd0:    dec.newop = OP_BEQ;
          3'd1:    dec.newop = OP_BNE;
          3'd4:    dec.newop = OP_BLT;
          3'd5:    dec.newop = OP_BGE;
          3'd6:    dec.newop = OP_BLTU;
          3'd7:    dec.newop = OP_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm = imm_i;
        dec.rs2 = '0;
        case (funct3)
          3'd0:    dec.newop = OP_LB;
          3'd1:    dec.newop = OP_LH;
          3'd2:    dec.newop = OP_LW;
          3'd4:    dec.newop = OP_LBU;
          3'd5:    dec.newop = OP_LHU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.imm = imm_s;
        dec.rd  = '0;
        case (funct3)
          3'd0:    dec.newop = OP_SB;
          3'd1:    dec.newop = OP_SH;
          3'd2:    dec.newop = OP_SW;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM, OPC_OP: begin
        // OP-IMM and OP share ALU ops; only OP uses funct7 to pick SUB.
        if (opcode == OPC_OP_IMM) begin
          dec.rs2 = '0;
          dec.imm = (funct3 == 3'd1 || funct3 == 3'd5) ? imm_sh : imm_i;
        end
        case (funct3)
          3'd0:    dec.newop = (opcode == OPC_OP && funct7[5]) ? OP_SUB : OP_ADD;
          3'd1:    dec.newop = OP_SLL;
          3'd2:    dec.newop = OP_SLT;
          3'd3:    dec.newop = OP_SLTU;
          3'd4:    dec.newop = OP_XOR;
          3'd5:    dec.newop = funct7[5] ? OP_SRA : OP_SRL;
          3'd6:    dec.newop = OP_OR;
          default: dec.newop = OP_AND;
        endcase
        if (!f7_ok && (opcode == OPC_OP || funct3 == 3'd1 || funct3 == 3'd5))
          dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) dec.newop = OP_NOP;
    dec.wr_rd = !dec.illegal && (opcode != OPC_STORE) && (opcode != OPC_BRANCH)
                && (in_inst != 32'h0000_0013);
  end

  assign in_ready  = (count_q != (PTR_W+1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Next-state for pointers and occupancy; flush overrides push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
      else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  // Pointer and occupancy registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage write at the push edge.
  // NOTE: storage is not reset; entries are only visible through count, so stale data never escapes.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= dec;
  end

  assign head_entry  = out_valid ? mem_q[head_q] : '0;
  assign classop_out = head_entry.classop;
  assign newop_out   = head_entry.newop;
  assign pc_out      = head_entry.pc;
  assign rs1_out     = head_entry.rs1;
  assign rs2_out     = head_entry.rs2;
  assign rd_out      = head_entry.rd;
  assign imm_out     = head_entry.imm;
  assign wr_rd_out   = head_entry.wr_rd;
  assign lock_prefix = head_entry.lock;
  assign illegal_out = head_entry.illegal;
  assign count       = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_inst;
  logic [XLEN-1:0]       in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [CLASS_OP_W-1:0] classop_out;
  logic [NEWOP_W-1:0]    newop_out;
  logic [XLEN-1:0]       pc_out;
  logic [REG_SEL_W-1:0]  rs1_out, rs2_out, rd_out;
  logic [XLEN-1:0]       imm_out;
  logic                  wr_rd_out, lock_prefix, illegal_out;
  logic [PTR_W:0]        count;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .classop_out(classop_out), .newop_out(newop_out), .pc_out(pc_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .imm_out(imm_out),
    .wr_rd_out(wr_rd_out), .lock_prefix(lock_prefix), .illegal_out(illegal_out),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  classop;
    newop_e      newop;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    bit          wr_rd, lock, illegal;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Per-funct3 op tables; OP_NOP marks an encoding with no legal meaning.
  newop_e load_ops [8] = '{OP_LB, OP_LH, OP_LW, OP_NOP, OP_LBU, OP_LHU, OP_NOP, OP_NOP};
  newop_e store_ops[8] = '{OP_SB, OP_SH, OP_SW, OP_NOP, OP_NOP, OP_NOP, OP_NOP, OP_NOP};
  newop_e br_ops   [8] = '{OP_BEQ, OP_BNE, OP_NOP, OP_NOP, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  newop_e alu_ops  [8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
  logic [6:0] opc_tab[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode built from the instruction-set rules with arithmetic shifts.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t        e;
    logic [6:0]  opc = inst[6:0];
    logic [2:0]  f3  = inst[14:12];
    logic [6:0]  f7  = inst[31:25];
    bit          f7_ok = (f7 == 7'h00) || (f7 == 7'h20);
    logic [31:0] top = 32'($signed(inst) >>> 31);
    logic [31:0] i_imm = 32'($signed(inst) >>> 20);
    logic [31:0] s_imm = (32'($signed(inst) >>> 25) << 5) | 32'(inst[11:7]);
    logic [31:0] b_imm = (top << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
    logic [31:0] u_imm = inst & 32'hFFFF_F000;
    logic [31:0] j_imm = (top << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
    e.classop = opc;
    e.pc      = pc;
    e.rs1     = inst[19:15];
    e.rs2     = inst[24:20];
    e.rd      = inst[11:7];
    e.lock    = !(inst[4] || inst[6]);
    e.imm     = 32'd0;
    e.newop   = OP_NOP;
    case (opc)
      7'h37: begin e.newop = OP_LUI;   e.imm = u_imm; e.rs1 = 0; e.rs2 = 0; end
      7'h17: begin e.newop = OP_AUIPC; e.imm = u_imm; e.rs1 = 0; e.rs2 = 0; end
      7'h6F: begin e.newop = OP_JAL;   e.imm = j_imm; e.rs1 = 0; e.rs2 = 0; end
      7'h67: begin e.newop = OP_JALR;  e.imm = i_imm; e.rs2 = 0; end
      7'h63: begin e.newop = br_ops[f3];    e.imm = b_imm; e.rd = 0; end
      7'h03: begin e.newop = load_ops[f3];  e.imm = i_imm; e.rs2 = 0; end
      7'h23: begin e.newop = store_ops[f3]; e.imm = s_imm; e.rd = 0; end
      7'h13: begin
        e.rs2 = 0;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.imm   = 32'(inst[24:20]);
          e.newop = !f7_ok ? OP_NOP : (f3 == 3'd5 && f7 == 7'h20) ? OP_SRA : alu_ops[f3];
        end else begin
          e.imm   = i_imm;
          e.newop = alu_ops[f3];
        end
      end
      7'h33: e.newop = !f7_ok ? OP_NOP :
                       (f7 == 7'h20 && f3 == 3'd0) ? OP_SUB :
                       (f7 == 7'h20 && f3 == 3'd5) ? OP_SRA : alu_ops[f3];
      default: e.newop = OP_NOP;
    endcase
    e.illegal = (e.newop == OP_NOP);
    e.wr_rd   = !e.illegal && opc != 7'h23 && opc != 7'h63 && inst != 32'h0000_0013;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom();
    int k = $urandom_range(0, 10);
    if (k == 10) return 32'h0000_0013;
    if (k < 9) r[6:0] = opc_tab[k];
    if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return r;
  endfunction

  // Compare every output with the model head, then advance the model as the edge will.
  task automatic compare_and_advance();
    exp_t e;
    int   sz = exp_q.size();
    check("count", 64'(count), 64'(sz));
    check("out_valid", 64'(out_valid), 64'(sz != 0));
    check("in_ready", 64'(in_ready), 64'(sz != DEPTH));
    if (sz != 0) e = exp_q[0];
    else begin
      e = '{classop: 7'd0, newop: OP_NOP, pc: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
            imm: 32'd0, wr_rd: 1'b0, lock: 1'b0, illegal: 1'b0};
    end
    check("classop", 64'(classop_out), 64'(e.classop));
    check("newop", 64'(newop_out), 64'(e.newop));
    check("pc", 64'(pc_out), 64'(e.pc));
    check("rs1", 64'(rs1_out), 64'(e.rs1));
    check("rs2", 64'(rs2_out), 64'(e.rs2));
    check("rd", 64'(rd_out), 64'(e.rd));
    check("imm", 64'(imm_out), 64'(e.imm));
    check("wr_rd", 64'(wr_rd_out), 64'(e.wr_rd));
    check("lock", 64'(lock_prefix), 64'(e.lock));
    check("illegal", 64'(illegal_out), 64'(e.illegal));
    if (flush) exp_q.delete();
    else begin
      if (out_ready && sz != 0) void'(exp_q.pop_front());
      if (in_valid && sz != DEPTH) exp_q.push_back(ref_decode(in_inst, in_pc));
    end
  endtask

  // One clock cycle: drive just after a rising edge, check on the falling edge.
  task automatic cycle(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit rdy, input bit fl);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    compare_and_advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_newop", 64'(newop_out), 64'(OP_NOP));
    check("rst_imm", 64'(imm_out), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // addi x1,x0,5 appears one cycle after the push.
    cycle(1, 32'h0050_0093, 32'h0, 0, 0);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_newop", 64'(newop_out), 64'(OP_ADD));
    check("addi_rd", 64'(rd_out), 64'd1);
    check("addi_rs1", 64'(rs1_out), 64'd0);
    check("addi_rs2", 64'(rs2_out), 64'd0);
    check("addi_imm", 64'(imm_out), 64'd5);
    check("addi_wr_rd", 64'(wr_rd_out), 64'd1);
    check("addi_illegal", 64'(illegal_out), 64'd0);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // Fill, then pop while pushing: the push is refused while full.
    for (int i = 0; i < DEPTH; i++) cycle(1, rand_inst(), 32'h100 + 32'(i * 4), 0, 0);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    cycle(1, rand_inst(), 32'h200, 1, 0);
    check("pop_when_full_count", 64'(count), 64'd3);
    cycle(1, rand_inst(), 32'h204, 0, 0);
    check("refill_count", 64'(count), 64'd4);
    for (int i = 0; i < DEPTH; i++) cycle(0, 32'h0, 32'h0, 1, 0);

    // Branch with negative B-immediate.
    cycle(1, 32'hFE00_0EE3, 32'h300, 0, 0);
    check("beq_newop", 64'(newop_out), 64'(OP_BEQ));
    check("beq_imm", 64'(imm_out), 64'hFFFF_FFFC);
    check("beq_wr_rd", 64'(wr_rd_out), 64'd0);
    check("beq_rd", 64'(rd_out), 64'd0);

    // Bad opcode queued behind the branch; branch pops in the same cycle.
    cycle(1, 32'h0000_007F, 32'h304, 1, 0);
    check("bad_illegal", 64'(illegal_out), 64'd1);
    check("bad_newop", 64'(newop_out), 64'(OP_NOP));
    check("bad_wr_rd", 64'(wr_rd_out), 64'd0);
    check("bad_pc", 64'(pc_out), 64'h304);

    // Flush with push and pop requested together.
    cycle(1, rand_inst(), 32'h308, 0, 0);
    cycle(1, rand_inst(), 32'h30C, 0, 0);
    check("pre_flush_count", 64'(count), 64'd3);
    cycle(1, rand_inst(), 32'h310, 1, 1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges.
    cycle(1, rand_inst(), 32'h400, 0, 0);
    cycle(1, rand_inst(), 32'h404, 0, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    cycle(1, 32'h0050_0093, 32'h500, 0, 0);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_pc", 64'(pc_out), 64'h500);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, rand_inst(), $urandom(),
            $urandom_range(0, 1) != 0, $urandom_range(0, 31) == 0);
    end
    cycle(0, 32'h0, 32'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
